// File: rtl/gru_fx_pkg.sv
// gru_fx_pkg: fixed-point defaults and the saturating/rounding helpers
// shared by the GRU fixed-point blocks.
package gru_fx_pkg;
    localparam int DATABIT = 16;
    localparam int FRAC    = 14;
    localparam int ONE     = 1 << FRAC;

    typedef logic signed [DATABIT-1:0] word_t;
    typedef logic signed [2*DATABIT:0] wide_t;

    localparam wide_t MAXV = wide_t'(2 ** (DATABIT - 1) - 1);
    localparam wide_t MINV = -wide_t'(2 ** (DATABIT - 1));

    // Returns {sat_flag, value}.
    function automatic logic [DATABIT:0] fx_sat(input wide_t v);
        logic hi, lo;
        hi = v > MAXV;
        lo = v < MINV;
        return {hi | lo, hi ? MAXV[DATABIT-1:0] : lo ? MINV[DATABIT-1:0] : v[DATABIT-1:0]};
    endfunction

    // Full product, round half up, arithmetic shift, then clamp.
    function automatic logic [DATABIT:0] fx_mul_rnd(input word_t a, input word_t b);
        wide_t p;
        p = (wide_t'(a) * wide_t'(b) + wide_t'(ONE / 2)) >>> FRAC;
        return fx_sat(p);
    endfunction
endpackage

// File: rtl/gru_gate_grad_lane.sv
// gru_gate_grad_lane: three-stage datapath computing g(zt)*xt*(ht1-htb)
// for one lane; the sat flag travels with the beat.
module gru_gate_grad_lane
    import gru_fx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               mode,
    input  logic [DATABIT-1:0] xt,
    input  logic [DATABIT-1:0] htb,
    input  logic [DATABIT-1:0] ht1,
    input  logic [DATABIT-1:0] zt,
    output logic [DATABIT-1:0] result,
    output logic               sat
);
    logic [DATABIT:0] d, b0, p, ab, g1, r;
    word_t a1, b1, d1, x1, g2, p2;
    logic m1, s1, s2;

    always_comb begin
        d  = fx_sat(wide_t'($signed(ht1)) - wide_t'($signed(htb)));
        b0 = fx_sat(wide_t'(ONE) - wide_t'($signed(zt)));
        p  = fx_mul_rnd(x1, d1);
        ab = fx_mul_rnd(a1, b1);
        g1 = fx_sat(wide_t'(ONE) - wide_t'($signed(ab[DATABIT-1:0])));
        r  = fx_mul_rnd(g2, p2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {a1, b1, d1, x1, m1, s1} <= '0;
            {g2, p2, s2}             <= '0;
            {result, sat}            <= '0;
        end else if (!stall) begin
            a1     <= zt;
            b1     <= mode ? zt : b0[DATABIT-1:0];
            d1     <= d[DATABIT-1:0];
            x1     <= xt;
            m1     <= mode;
            s1     <= d[DATABIT] | (~mode & b0[DATABIT]);
            p2     <= p[DATABIT-1:0];
            g2     <= m1 ? g1[DATABIT-1:0] : ab[DATABIT-1:0];
            s2     <= s1 | p[DATABIT] | ab[DATABIT] | (m1 & g1[DATABIT]);
            result <= r[DATABIT-1:0];
            sat    <= s2 | r[DATABIT];
        end
    end
endmodule

// File: rtl/gru_gate_grad_vec.sv
// gru_gate_grad_vec: LANES-wide pipelined GRU gate-gradient unit with one
// shared valid/ready handshake and a sticky saturation flag.
module gru_gate_grad_vec
    import gru_fx_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATABIT-1:0] xt,
    input  logic [LANES*DATABIT-1:0] htb,
    input  logic [LANES*DATABIT-1:0] ht1,
    input  logic [LANES*DATABIT-1:0] zt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DATABIT-1:0] result,
    output logic [LANES-1:0]         out_sat,
    output logic                     sat_sticky,
    input  logic                     clr
);
    logic [2:0] v;
    logic stall;

    assign out_valid = v[2];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    always_ff @(posedge clk) begin
        if (rst)
            v <= '0;
        else if (!stall)
            v <= {v[1:0], in_valid};
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            sat_sticky <= 1'b0;
        else if (out_valid && out_ready && |out_sat)
            sat_sticky <= 1'b1;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gru_gate_grad_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .stall  (stall),
            .mode   (mode),
            .xt     (xt[i*DATABIT +: DATABIT]),
            .htb    (htb[i*DATABIT +: DATABIT]),
            .ht1    (ht1[i*DATABIT +: DATABIT]),
            .zt     (zt[i*DATABIT +: DATABIT]),
            .result (result[i*DATABIT +: DATABIT]),
            .sat    (out_sat[i])
        );
    end
endmodule

// File: tb/tb_gru_gate_grad_vec.sv
// tb_gru_gate_grad_vec: scoreboard bench with an arithmetic reference model
// for the gate-gradient unit.
module tb_gru_gate_grad_vec;
    localparam int L = 4;
    localparam int W = 16;
    localparam int F = 14;
    localparam longint ONE = 1 << F;

    logic clk = 0, rst = 1, mode = 0, in_valid = 0, out_ready = 1, clr = 0;
    logic in_ready, out_valid, sat_sticky;
    logic [L*W-1:0] xt = '0, htb = '0, ht1 = '0, zt = '0, result;
    logic [L-1:0] out_sat;

    typedef struct {
        logic [L*W-1:0] res;
        logic [L-1:0]   sat;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0, seen = 0;
    bit done = 0;

    always #5 clk = ~clk;

    gru_gate_grad_vec #(.LANES(L)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .xt(xt), .htb(htb), .ht1(ht1), .zt(zt), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_sat(out_sat), .sat_sticky(sat_sticky), .clr(clr)
    );

    function automatic longint clamp(input longint v, inout bit s);
        longint hi = (longint'(1) << (W - 1)) - 1;
        longint lo = -(longint'(1) << (W - 1));
        if (v > hi) begin s = 1; return hi; end
        if (v < lo) begin s = 1; return lo; end
        return v;
    endfunction

    function automatic longint mr(input longint a, input longint b, inout bit s);
        return clamp((a * b + ONE / 2) >>> F, s);
    endfunction

    // g(z) * x * (ht1 - htb), every step clamped, per lane.
    function automatic exp_t model(input logic [L*W-1:0] x, h1, hb, z, input logic m);
        exp_t e;
        for (int i = 0; i < L; i++) begin
            bit s = 0;
            longint xi = longint'($signed(x[i*W +: W]));
            longint zi = longint'($signed(z[i*W +: W]));
            longint d, b, p, g, r;
            d = clamp(longint'($signed(h1[i*W +: W])) - longint'($signed(hb[i*W +: W])), s);
            b = m ? zi : clamp(ONE - zi, s);
            p = mr(xi, d, s);
            g = mr(zi, b, s);
            if (m) g = clamp(ONE - g, s);
            r = mr(g, p, s);
            e.res[i*W +: W] = r[W-1:0];
            e.sat[i] = s;
        end
        return e;
    endfunction

    function automatic logic [L*W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string n, input logic [L*W-1:0] act, input logic [L*W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, want);
        end
    endtask

    task automatic send(input logic [L*W-1:0] x, h1, hb, z, input logic m);
        int n = 0;
        xt = x; ht1 = h1; htb = hb; zt = z; mode = m; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stuck low");
        end else
            q.push_back(model(x, h1, hb, z, m));
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d beats missing", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every transferred beat, checks holds on stall.
    logic [L*W-1:0] held;
    bit hv = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) hv = 0;
        else begin
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (hv) chk("stall_hold", result, held);
                held = result;
                hv = 1;
            end else hv = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got %h want none", result);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("out_sat", out_sat, e.sat);
                    seen++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, s0;
        logic [L*W-1:0] sx, sh1, shb;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sticky", sat_sticky, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // sigmoid and latency
        send({4{16'd16384}}, {4{16'd8192}}, '0, {4{16'd8192}}, 0);
        wait_out(lat);
        chk("t1_latency", lat, 3);
        chk("t1_result", result, {4{16'd2048}});
        chk("t1_sat", out_sat, 0);
        drain();

        // tanh, then alternating modes back to back
        send({4{16'd16384}}, {4{16'd8192}}, '0, {4{16'd8192}}, 1);
        wait_out(lat);
        chk("t2_result", result, {4{16'd6144}});
        drain();
        for (int i = 0; i < 6; i++)
            send({4{16'd16384}}, {4{16'd8192}}, '0, {4{16'd8192}}, i[0]);
        drain();

        // saturation and sticky clear
        sx = {4{16'h7fff}}; sh1 = {4{16'h7fff}}; shb = {4{16'h8000}};
        send(sx, sh1, shb, '0, 1);
        wait_out(lat);
        chk("t3_result", result, {4{16'h7fff}});
        chk("t3_sat", out_sat, 4'hf);
        drain();
        chk("t3_sticky_set", sat_sticky, 1);
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        chk("t3_sticky_clr", sat_sticky, 0);
        clr = 1;
        send(sx, sh1, shb, '0, 1);
        drain();
        chk("t3_clr_wins", sat_sticky, 0);
        clr = 0;

        // backpressure mid-stream
        s0 = seen;
        fork
            for (int i = 0; i < 8; i++) send(rnd(), rnd(), rnd(), rnd(), 1'($urandom));
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        chk("t4_count", seen - s0, 8);

        // distinct lanes, negative z in sigmoid mode
        send({16'd20000, 16'd3000, 16'hE000, 16'd16384},
             {16'd30000, 16'hD120, 16'd4000, 16'd8192},
             {16'hD8F0, 16'd5000, 16'hF060, 16'd0},
             {16'hC180, 16'd12000, 16'd8192, 16'hF000}, 0);
        wait_out(lat);
        chk("t5_lane0", result[15:0], 16'hF600);
        drain();

        // random stream under random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(rnd(), rnd(), rnd(), rnd(), 1'($urandom));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom);
                end
                out_ready = 1;
            end
        join
        drain();

        // reset with two beats in flight
        send(rnd(), rnd(), rnd(), rnd(), 0);
        send(rnd(), rnd(), rnd(), rnd(), 1);
        rst = 1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("t6_flush", out_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_stale", out_valid, 0);
        end
        chk("end_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
